fetch_stage: RTL and testbench

//  Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the word-addressed

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/if_id_register.sv | 26 ++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, IF/ID payload layout and the NOP word.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BUBBLE = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALT   = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: synchronous active-low reset, flush to an empty NOP slot, load-enable.
module if_id_register
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t EMPTY = '{instruction: NOP_WORD, pc_plus4: '0, valid: 1'b0};

  // Flush beats load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= EMPTY;
    end else if (flush) begin
      q <= EMPTY;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, PC+4 adder, fetch FSM (bubble/run/halt) and the IF/ID register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectTarget,
  output logic [XLEN-1:0] IMemAddress,
  input  logic [XLEN-1:0] IMemInstruction,
  output logic [XLEN-1:0] IF_ID_Instruction,
  output logic [XLEN-1:0] IF_ID_PCPlus4,
  output logic            IF_ID_Valid,
  output logic            Halted
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            halt_hit;
  logic            halted;
  logic            ifid_load_c;
  logic            ifid_flush_c;
  if_id_t          ifid_d;
  if_id_t          ifid_q;

  assign pc_plus4    = pc + XLEN'(4);
  assign redirect_pc = RedirectTarget & ~XLEN'(3);
  assign halt_hit    = (IMemInstruction == HALT_WORD);

  // PC and fetch FSM; priority Reset > Redirect > Stall > advance.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc     <= RESET_PC;
      state  <= FETCH_BUBBLE;
      halted <= 1'b0;
    end else if (Redirect) begin
      pc     <= redirect_pc;
      state  <= FETCH_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        FETCH_BUBBLE: state <= FETCH_RUN;
        FETCH_RUN: begin
          if (!Stall) begin
            if (halt_hit) begin
              state  <= FETCH_HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        FETCH_HALT: halted <= 1'b1;
        default: begin
          state  <= FETCH_BUBBLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID control: HALT holds the NOP it was flushed with, so it needs neither load nor flush.
  always_comb begin
    ifid_load_c  = 1'b0;
    ifid_flush_c = 1'b0;
    if (Redirect || state == FETCH_BUBBLE) begin
      ifid_flush_c = 1'b1;
    end else if (state == FETCH_RUN && !Stall) begin
      if (halt_hit) begin
        ifid_flush_c = 1'b1;
      end else begin
        ifid_load_c = 1'b1;
      end
    end
  end

  assign ifid_d = '{instruction: IMemInstruction, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_register u_if_id (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (ifid_load_c),
    .flush (ifid_flush_c),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IMemAddress       = pc;
  assign IF_ID_Instruction = ifid_q.instruction;
  assign IF_ID_PCPlus4     = ifid_q.pc_plus4;
  assign IF_ID_Valid       = ifid_q.valid;
  assign Halted            = halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural 1024-word instruction memory.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        Halted;

  logic [31:0] mem [1024];
  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  assign IMemInstruction = mem[IMemAddress[11:2]];

  fetch_stage dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Stall             (Stall),
    .Redirect          (Redirect),
    .RedirectTarget    (RedirectTarget),
    .IMemAddress       (IMemAddress),
    .IMemInstruction   (IMemInstruction),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .Halted            (Halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Checks a full valid IF/ID slot plus the current fetch address.
  task automatic check_run(input string tag, input logic [31:0] addr,
                           input logic [31:0] instr, input logic [31:0] p4);
    check({tag, ".addr"},  IMemAddress, addr);
    check({tag, ".instr"}, IF_ID_Instruction, instr);
    check({tag, ".pc4"},   IF_ID_PCPlus4, p4);
    check({tag, ".valid"}, 32'(IF_ID_Valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;

    // 1. reset then sequential fetch
    step(); step();
    check("rst.addr",   IMemAddress, 32'h0);
    check("rst.instr",  IF_ID_Instruction, 32'h0);
    check("rst.pc4",    IF_ID_PCPlus4, 32'h0);
    check("rst.valid",  32'(IF_ID_Valid), 32'd0);
    check("rst.halted", 32'(Halted), 32'd0);
    Reset = 1'b1;
    step();
    check("bubble.valid", 32'(IF_ID_Valid), 32'd0);
    check("bubble.addr",  IMemAddress, 32'h0);
    step(); check_run("seq0", 32'h04, 32'hA000_0000, 32'h04);
    step(); check_run("seq1", 32'h08, 32'hA000_0001, 32'h08);
    step(); check_run("seq2", 32'h0C, 32'hA000_0002, 32'h0C);
    step(); check_run("seq3", 32'h10, 32'hA000_0003, 32'h10);

    // 2. stall three cycles at 0x10
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_run("stall", 32'h10, 32'hA000_0003, 32'h10);
    end
    Stall = 1'b0;
    step(); check_run("unstall", 32'h14, 32'hA000_0004, 32'h14);
    step(); step(); step();
    check_run("to20", 32'h20, 32'hA000_0007, 32'h20);

    // 3. redirect to unaligned 0x43, then again with stall asserted
    for (int r = 0; r < 2; r++) begin
      Redirect = 1'b1; Stall = (r == 1); RedirectTarget = 32'h43;
      step();
      Redirect = 1'b0; Stall = 1'b0;
      check("redir.addr",  IMemAddress, 32'h40);
      check("redir.valid", 32'(IF_ID_Valid), 32'd0);
      check("redir.instr", IF_ID_Instruction, 32'h0);
      check("redir.pc4",   IF_ID_PCPlus4, 32'h0);
      step(); check_run("redir.next", 32'h44, 32'hA000_0010, 32'h44);
    end

    // 4. halt word at 0x08
    mem[2] = 32'hFFFF_FFFF;
    Redirect = 1'b1; RedirectTarget = 32'h0;
    step(); Redirect = 1'b0;
    step(); check_run("pre_halt0", 32'h04, 32'hA000_0000, 32'h04);
    step(); check_run("pre_halt1", 32'h08, 32'hA000_0001, 32'h08);
    for (int i = 0; i < 4; i++) begin
      Stall = i[0];
      step();
      check("halt.addr",   IMemAddress, 32'h08);
      check("halt.halted", 32'(Halted), 32'd1);
      check("halt.valid",  32'(IF_ID_Valid), 32'd0);
      check("halt.instr",  IF_ID_Instruction, 32'h0);
    end
    Stall = 1'b0;
    Redirect = 1'b1; RedirectTarget = 32'h0;
    step(); Redirect = 1'b0;
    check("unhalt.halted", 32'(Halted), 32'd0);
    check("unhalt.addr",   IMemAddress, 32'h0);
    step(); check_run("resume", 32'h04, 32'hA000_0000, 32'h04);
    step(); step();
    check("rehalt.halted", 32'(Halted), 32'd1);

    // 5. reset while halted and stalled
    Reset = 1'b0; Stall = 1'b1;
    step();
    check("rst_halt.addr",   IMemAddress, 32'h0);
    check("rst_halt.halted", 32'(Halted), 32'd0);
    check("rst_halt.valid",  32'(IF_ID_Valid), 32'd0);
    Reset = 1'b1; Stall = 1'b0;
    mem[2] = 32'hA000_0002;
    step(); check("rst_halt.bubble", 32'(IF_ID_Valid), 32'd0);
    step(); check_run("rst_halt.run", 32'h04, 32'hA000_0000, 32'h04);

    // 6. PC wrap at the top of the address space
    Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
    step(); Redirect = 1'b0;
    check("wrap.addr", IMemAddress, 32'hFFFF_FFFC);
    step(); check_run("wrap", 32'h0, 32'hA000_03FF, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
